// File: rtl/sa_ctrl.sv
// Bit-serial addition controller: feeds an external one-bit serial adder LSB first
// and collects its sum bits into a WIDTH+1 result (sum plus carry out).
module sa_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sa_a,
  output logic             sa_b,
  output logic             sa_clr,
  input  logic             sa_out
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH:0]   result;
  logic [WIDTH:0]   result_nxt;
  logic             a_bit;
  logic             b_bit;

  // The adder's LSB-first output enters at the top, so after WIDTH+1 shifts
  // the first sample has reached bit 0 and the final carry sits in bit WIDTH.
  assign result_nxt = {sa_out, result[WIDTH:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= op_a;
            b_reg <= op_b;
            cnt   <= '0;
            state <= CLEAR;
          end
        end
        CLEAR: state <= SHIFT;
        SHIFT: begin
          result <= result_nxt;
          if (cnt == CNT_LAST) begin
            sum   <= result_nxt[WIDTH-1:0];
            cout  <= result_nxt[WIDTH];
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    a_bit = 1'b0;
    b_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CW'(i)) begin
        a_bit = a_reg[i];
        b_bit = b_reg[i];
      end
    end
  end

  // The extra cnt==WIDTH step feeds zeros so the adder emits its stored carry.
  assign sa_a   = (state == SHIFT) && (cnt != CNT_LAST) && a_bit;
  assign sa_b   = (state == SHIFT) && (cnt != CNT_LAST) && b_bit;
  assign sa_clr = (state == IDLE) || (state == CLEAR);
  assign busy   = (state == CLEAR) || (state == SHIFT);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_sa_ctrl.sv
// Bench for sa_ctrl: a behavioural serial adder plus a timeline model of when
// each output must show what, checked every cycle, with directed literal pins.
module tb_sa_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         sa_a;
  logic         sa_b;
  logic         sa_clr;
  logic         sa_out;
  logic         sa_c = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  sa_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .sa_a(sa_a), .sa_b(sa_b), .sa_clr(sa_clr), .sa_out(sa_out)
  );

  always #5 clk = ~clk;

  // Serial full adder with a clearable carry flop.
  assign sa_out = sa_a ^ sa_b ^ sa_c;
  always @(posedge clk) begin
    if (sa_clr) sa_c <= 1'b0;
    else        sa_c <= (sa_a & sa_b) | (sa_a & sa_c) | (sa_b & sa_c);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: an accepted request at edge k means the cycle after edge
  // k+r shows CLEAR (r=0), serial bit r-1 (r=1..W+1) and the done pulse (r=W+2).
  bit op_valid = 1'b0;
  int edge_cnt = 0;
  int k_edge   = 0;
  int m_a      = 0;
  int m_b      = 0;
  int exp_sum  = 0;
  int exp_cout = 0;

  always @(negedge rst) begin
    op_valid = 1'b0;
    exp_sum  = 0;
    exp_cout = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      edge_cnt++;
      if (op_valid && edge_cnt == k_edge + W + 2) begin
        exp_sum  = (m_a + m_b) % (1 << W);
        exp_cout = ((m_a + m_b) >> W) & 1;
      end
      if (start && (!op_valid || edge_cnt >= k_edge + W + 4)) begin
        op_valid = 1'b1;
        k_edge   = edge_cnt;
        m_a      = int'(op_a);
        m_b      = int'(op_b);
      end
    end
  end

  always @(negedge clk) begin
    int rel;
    int ebusy, edone, eclr, ea, eb;
    ebusy = 0; edone = 0; eclr = 1; ea = 0; eb = 0;
    if (op_valid) begin
      rel = edge_cnt - k_edge;
      if (rel == 0) begin
        ebusy = 1;
      end else if (rel >= 1 && rel <= W + 1) begin
        ebusy = 1;
        eclr  = 0;
        if (rel - 1 < W) begin
          ea = (m_a >> (rel - 1)) & 1;
          eb = (m_b >> (rel - 1)) & 1;
        end
      end else if (rel == W + 2) begin
        edone = 1;
        eclr  = 0;
      end
    end
    chk("busy", 32'(busy), ebusy);
    chk("done", 32'(done), edone);
    chk("sa_clr", 32'(sa_clr), eclr);
    chk("sa_a", 32'(sa_a), ea);
    chk("sa_b", 32'(sa_b), eb);
    chk("sum", 32'(sum), exp_sum);
    chk("cout", 32'(cout), exp_cout);
  end

  // Issue one request, scramble the operands afterwards, wait (bounded) for done.
  task automatic run_op(input int a, input int b, input int es, input int ec,
                        output int seq, output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    seq = 0;
    @(posedge clk); #1;
    start = 1'b1; op_a = W'(a); op_b = W'(b);
    @(posedge clk); #1;
    start = 1'b0; op_a = ~(W'(a)); op_b = ~(W'(b));
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (i == 0) chk("clr_in_clear", 32'(sa_clr), 1);
      if (i >= 1 && i <= W + 1) seq = seq | (int'(sa_a) << (i - 1));
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk("done_seen", 32'(got), 1);
    if (got) begin
      chk("lit_sum", 32'(sum), es);
      chk("lit_cout", 32'(cout), ec);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq, lat, ndone, s1, s2, d1, d2;
    #1 rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_sa_clr", 32'(sa_clr), 1);
    chk("rst_sa_a", 32'(sa_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(5, 3, 8, 0, seq, lat);
    chk("latency", lat + 1, 7);
    chk("sa_a_seq", seq, 32'b00101);

    run_op(15, 1, 0, 1, seq, lat);

    run_op(15, 15, 14, 1, seq, lat);
    run_op(0, 0, 0, 0, seq, lat);

    // start held high across two operations, operands changed mid-SHIFT
    @(posedge clk); #1;
    start = 1'b1; op_a = 4'd3; op_b = 4'd4;
    ndone = 0; s1 = -1; s2 = -1; d1 = 0; d2 = 0;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      @(negedge clk);
      if (i == 3) begin
        op_a = 4'd7;
        op_b = 4'd7;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin s1 = int'(sum); d1 = i; end
        else begin s2 = int'(sum); d2 = i; end
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("held_done_count", ndone, 2);
    chk("held_sum1", s1, 7);
    chk("held_sum2", s2, 14);
    chk("held_gap", d2 - d1, W + 4);

    // asynchronous reset in SHIFT at cnt=2
    @(posedge clk); #1;
    start = 1'b1; op_a = 4'd4; op_b = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_sa_a", 32'(sa_a), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_done", 32'(done), 0);
    chk("async_sum", 32'(sum), 0);
    chk("async_cout", 32'(cout), 0);
    chk("async_sa_a", 32'(sa_a), 0);
    chk("async_sa_clr", 32'(sa_clr), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_op(9, 6, 15, 0, seq, lat);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a, b, (a + b) & 15, ((a + b) >> 4) & 1, seq, lat);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_ctrl.md
SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; the range is 2..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous assert, active-low (0 = reset).
REQ-004 start  input  1  request one addition; sampled only in IDLE.
REQ-005 op_a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 op_b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 busy  output  1  high in CLEAR and SHIFT.
REQ-008 done  output  1  one-cycle pulse; sum and cout are valid.
REQ-009 sum  output  WIDTH  result bits [WIDTH-1:0]; held until the next accepted start.
REQ-010 cout  output  1  carry out of the MSB; held with sum.
REQ-011 sa_a  output  1  serial bit A to the serial adder, LSB first.
REQ-012 sa_b  output  1  serial bit B to the serial adder, LSB first.
REQ-013 sa_clr  output  1  active-high clear of the serial adder's carry flop; wired to the adder's rst port.
REQ-014 sa_out  input  1  adder sum bit; a combinational function of sa_a, sa_b and the stored carry.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, CLEAR, SHIFT, DONE.
REQ-016 IDLE with start=1 at an edge SHALL capture op_a/op_b into internal registers, clear the bit counter and go to CLEAR.
- sum and cout SHALL not change on this edge.
REQ-017 In IDLE with start=0, the FSM SHALL stay in IDLE.
REQ-018 CLEAR SHALL last exactly one cycle with sa_clr=1 and sa_a=sa_b=0, then go to SHIFT.
REQ-019 SHIFT SHALL last exactly WIDTH+1 cycles, indexed cnt=0..WIDTH.
REQ-020 In SHIFT, for cnt<WIDTH, sa_a=a_reg[cnt] and sa_b=b_reg[cnt].
REQ-021 In SHIFT at cnt=WIDTH, sa_a=sa_b=0, so sa_out equals the final carry.
REQ-022 At every SHIFT edge, sa_out SHALL be sampled into a result shift register (MSB-in, shifting right), WIDTH+1 bits.
REQ-023 After the cnt=WIDTH edge, the FSM SHALL go to DONE.
REQ-024 On that edge, sum SHALL load result[WIDTH-1:0] and cout SHALL load result[WIDTH].
REQ-025 DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE.
REQ-026 sa_clr SHALL be 0 in SHIFT and DONE, and 1 in IDLE, so the adder's carry is held cleared between operations.
REQ-027 Latency: start accepted at edge k -> CLEAR in cycle k+1 -> SHIFT in cycles k+2..k+WIDTH+2 -> done=1 in cycle k+WIDTH+3.
REQ-028 start SHALL be ignored in CLEAR, SHIFT and DONE.
- No queueing of requests.
- No operand change mid-operation.
REQ-029 Changes on op_a/op_b after acceptance SHALL not affect the result.
REQ-030 sum/cout SHALL equal (op_a+op_b) mod 2^WIDTH and bit WIDTH of op_a+op_b respectively.
REQ-031 The bit counter SHALL be sized ceil(log2(WIDTH+1)) bits and SHALL never exceed WIDTH.
REQ-032 All outputs SHALL be registered or decoded from state only, with no combinational path from start.

Reset
REQ-033 rst=0 SHALL asynchronously force the following, regardless of state, including mid-SHIFT:
- state=IDLE, cnt=0, a_reg=b_reg=0, result=0;
- busy=0, done=0, sum=0, cout=0;
- sa_a=sa_b=0, sa_clr=1.
REQ-034 An operation interrupted by reset SHALL be abandoned without a done pulse.
REQ-035 The first edge after rst deasserts SHALL sample start normally.

Verification
REQ-036 WIDTH=4, op_a=5, op_b=3, start pulse -> done exactly 7 cycles after the accept edge, sum=8, cout=0.
- sa_a serial sequence 1,0,1,0,0.
REQ-037 op_a=15, op_b=1 -> sum=0, cout=1.
REQ-038 Carry isolation, back-to-back: 15+15 (sum=14, cout=1), then immediately 0+0 -> sum=0, cout=0.
- sa_clr=1 in the CLEAR cycle between the two operations.
REQ-039 start held high continuously during an operation; op_a/op_b changed mid-SHIFT -> exactly one done per operation.
- Result matches the captured operands.
- The next operation starts on the first IDLE edge.
REQ-040 rst=0 asserted in SHIFT cnt=2 -> outputs at reset values immediately (asynchronous), with no done pulse.
- After release, 9+6 -> sum=15, cout=0.
REQ-041 Exhaustive 4-bit sweep: all 256 operand pairs against a reference model; sum/cout held stable between done pulses.
